// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the 8-bit synchronous FIFO.
// Prefetches into a 3-entry buffer and emits a valid/ready byte stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  bytes_sent
);

    logic [1:0]            occ;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] mem [3];
    logic [2:0]            level;
    logic                  pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Bytes buffered plus the one still in the FIFO's output register.
    assign level = {1'b0, occ} + {2'b00, in_flight};

    assign fifo_rd_en = !rst && fetch_en && !fifo_empty
                        && (level <= 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = mem[head];
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= 2'd0;
            head       <= 2'd0;
            tail       <= 2'd0;
            in_flight  <= 1'b0;
            bytes_sent <= '0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            in_flight <= fifo_rd_en;
            // fifo_data is only sampled the cycle after a read.
            if (in_flight) begin
                mem[tail] <= fifo_data;
                tail      <= wrap_inc(tail);
            end
            if (pop) begin
                head       <= wrap_inc(head);
                bytes_sent <= bytes_sent + CNT_WIDTH'(1);
            end
            occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule
